// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// Each clock shifts the work register right by one bit and corrects every BCD digit.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
) (
  input  logic                  SYS_CLK,
  input  logic                  RESET,
  input  logic                  Start,
  input  logic [4*DIGITS-1:0]   Bcd_In,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err,
  output logic [BIN_W-1:0]      Bin_Out
);
  localparam int BW = 4 * DIGITS;
  localparam int WW = BW + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, ERRD} state_t;

  state_t            state_q;
  logic [WW-1:0]     work_q, work_d, shifted;
  logic [CW-1:0]     cnt_q;
  logic              busy_q, done_q, err_q;
  logic [BIN_W-1:0]  bin_q;
  logic              bad_d;

  // A digit is at most 15 after the shift, so it never underflows when 3 is subtracted from digits of 8 and above.
  always_comb begin
    shifted = work_q >> 1;
    work_d  = shifted;
    for (int i = 0; i < DIGITS; i++) begin
      if (shifted[BIN_W+4*i +: 4] >= 4'd8)
        work_d[BIN_W+4*i +: 4] = shifted[BIN_W+4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    bad_d = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (Bcd_In[4*i +: 4] > 4'd9) bad_d = 1'b1;
    end
  end

  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            busy_q <= 1'b1;
            if (bad_d) begin
              state_q <= ERRD;
            end else begin
              work_q  <= {Bcd_In, {BIN_W{1'b0}}};
              cnt_q   <= '0;
              err_q   <= 1'b0;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(BIN_W - 1)) begin
            bin_q   <= work_d[BIN_W-1:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        ERRD: begin
          err_q   <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Err     = err_q;
  assign Bin_Out = bin_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: conversions, error operands, ignored Start, reset abort, back-to-back.
module tb_bcd_to_bin_seq;
  logic        SYS_CLK = 1'b0;
  logic        RESET   = 1'b1;
  logic        Start   = 1'b0;
  logic [15:0] Bcd_In  = '0;
  logic        Busy, Done, Err;
  logic [15:0] Bin_Out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(16)) dut (
    .SYS_CLK(SYS_CLK), .RESET(RESET), .Start(Start), .Bcd_In(Bcd_In),
    .Busy(Busy), .Done(Done), .Err(Err), .Bin_Out(Bin_Out)
  );

  always #5 SYS_CLK = ~SYS_CLK;
  always @(posedge SYS_CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  // Drive Start for one edge, then scramble Bcd_In to prove the loaded copy is used.
  task automatic start_conv(input logic [15:0] bcd);
    Start  = 1'b1;
    Bcd_In = bcd;
    tick();
    Start  = 1'b0;
    Bcd_In = 16'($urandom);
    chk("busy_after_accept", {31'b0, Busy}, 32'd1);
    chk("done_low_after_accept", {31'b0, Done}, 32'd0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!Done && lat < 40) begin
      tick();
      lat++;
      if (Busy && Done) chk("busy_done_excl", 32'd1, 32'd0);
    end
  endtask

  task automatic conv(input string tag, input logic [15:0] bcd, input logic [15:0] exp_bin,
                      input logic exp_err, input int exp_lat);
    int lat;
    start_conv(bcd);
    wait_done(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_bin"}, {16'b0, Bin_Out}, {16'b0, exp_bin});
    chk({tag, "_err"}, {31'b0, Err}, {31'b0, exp_err});
    chk({tag, "_busy"}, {31'b0, Busy}, 32'd0);
    tick();
    chk({tag, "_pulse"}, {31'b0, Done}, 32'd0);
  endtask

  initial begin
    int lat, t1, ndone;
    #1;
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_err",  {31'b0, Err},  32'd0);
    chk("rst_bin",  {16'b0, Bin_Out}, 32'd0);
    tick();
    tick();
    RESET = 1'b0;
    tick();

    conv("c1234", 16'h1234, 16'h04D2, 1'b0, 16);
    conv("c9999", 16'h9999, 16'h270F, 1'b0, 16);
    conv("c0000", 16'h0000, 16'h0000, 1'b0, 16);
    conv("c9999b", 16'h9999, 16'h270F, 1'b0, 16);
    conv("e12A4", 16'h12A4, 16'h270F, 1'b1, 1);
    conv("eA000", 16'hA000, 16'h270F, 1'b1, 1);
    conv("e000F", 16'h000F, 16'h270F, 1'b1, 1);

    // Start while busy is ignored; a valid accept clears Err.
    start_conv(16'h0042);
    chk("err_clr_on_accept", {31'b0, Err}, 32'd0);
    repeat (4) tick();
    Start  = 1'b1;
    Bcd_In = 16'h9999;
    tick();
    Start  = 1'b0;
    chk("busy_ignore", {31'b0, Busy}, 32'd1);
    wait_done(lat);
    chk("ign_lat", lat + 5, 32'd16);
    chk("ign_bin", {16'b0, Bin_Out}, 32'h002A);
    tick();

    // Reset mid-conversion discards it.
    start_conv(16'h0500);
    repeat (7) tick();
    RESET = 1'b1;
    #1;
    chk("abort_busy", {31'b0, Busy}, 32'd0);
    chk("abort_bin",  {16'b0, Bin_Out}, 32'd0);
    chk("abort_done", {31'b0, Done}, 32'd0);
    chk("abort_err",  {31'b0, Err}, 32'd0);
    tick();
    RESET = 1'b0;
    ndone = 0;
    repeat (20) begin
      tick();
      if (Done) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);
    conv("c0500", 16'h0500, 16'h01F4, 1'b0, 16);

    // Back-to-back: second Start lands in the Done cycle.
    start_conv(16'h0001);
    wait_done(lat);
    chk("b2b1_lat", lat, 32'd16);
    chk("b2b1_bin", {16'b0, Bin_Out}, 32'h0001);
    t1 = cyc;
    start_conv(16'h0100);
    wait_done(lat);
    chk("b2b_gap", cyc - t1, 32'd17);
    chk("b2b2_bin", {16'b0, Bin_Out}, 32'h0064);
    chk("b2b2_err", {31'b0, Err}, 32'd0);
    tick();
    chk("b2b2_pulse", {31'b0, Done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
